// File: rtl/jp_multi_reader_if.sv
// Pin-side and core-side signals of the multi-port game-pad reader.
// slave = reader, master = pads plus NES core.
interface jp_multi_reader_if #(
  parameter int N_PORTS = 2,
  parameter int N_BITS  = 8
);
  logic                        poll_req;
  logic [N_PORTS-1:0]          jp_data;
  logic                        jp_latch;
  logic                        jp_clk;
  logic [N_PORTS*N_BITS-1:0]   buttons;
  logic                        valid;
  logic                        busy;

  modport slave  (input  poll_req, jp_data,
                  output jp_latch, jp_clk, buttons, valid, busy);
  modport master (output poll_req, jp_data,
                  input  jp_latch, jp_clk, buttons, valid, busy);
endinterface

// File: rtl/jp_multi_reader.sv
// Serial reader for N 4021-style pads sharing latch/clock lines.
// Optional JP_DEBOUNCE_EN: a port's field updates only on two identical frames.
module jp_port_lane #(
  parameter int N_BITS = 8,
  parameter int IW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_i,
  input  logic              load_i,
  input  logic [IW-1:0]     idx_i,
  input  logic              data_i,
  output logic [N_BITS-1:0] btn_o
);
  logic [N_BITS-1:0] shift_q, btn_q;
`ifdef JP_DEBOUNCE_EN
  logic [N_BITS-1:0] prev_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '1;
      btn_q   <= '0;
`ifdef JP_DEBOUNCE_EN
      prev_q  <= '0;
`endif
    end else begin
      if (sample_i) shift_q[idx_i] <= data_i;
      if (load_i) begin
`ifdef JP_DEBOUNCE_EN
        // prev_q is kept in pressed polarity so its reset value means released
        if (~shift_q == prev_q) btn_q <= ~shift_q;
        prev_q <= ~shift_q;
`else
        btn_q <= ~shift_q;
`endif
      end
    end
  end

  assign btn_o = btn_q;
endmodule

module jp_multi_reader #(
  parameter int N_PORTS      = 2,
  parameter int N_BITS       = 8,
  parameter int CLK_DIV      = 50,
  parameter int LATCH_CYCLES = 100,
  parameter int POLL_CYCLES  = 1666667
) (
  input  logic            clk,
  input  logic            rst_n,
  jp_multi_reader_if.slave bus
);
  localparam int CMAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int TW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int IW   = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LATCH = 3'd1;
  localparam logic [2:0] LOW   = 3'd2;
  localparam logic [2:0] HIGH  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          pend_q, pend_d;
  logic          tmr_tc, sample, load;
  logic [N_PORTS-1:0][N_BITS-1:0] btn;

  assign tmr_tc = (tmr_q == TW'(POLL_CYCLES - 1));
  assign tmr_d  = tmr_tc ? '0 : tmr_q + 1'b1;

  // A request in the cycle pending is consumed wins over the clear
  always_comb begin
    pend_d = pend_q;
    if (state_q == IDLE && pend_q) pend_d = 1'b0;
    if (tmr_tc || bus.poll_req)    pend_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sample  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: if (pend_q) begin
        state_d = LATCH;
        cnt_d   = '0;
      end
      LATCH: if (cnt_q == CW'(LATCH_CYCLES - 1)) begin
        state_d = LOW;
        cnt_d   = '0;
        idx_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      LOW: if (cnt_q == CW'(CLK_DIV - 1)) begin
        sample  = 1'b1;
        state_d = HIGH;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      HIGH: if (cnt_q == CW'(CLK_DIV - 1)) begin
        cnt_d = '0;
        if (idx_q == IW'(N_BITS - 1)) begin
          // buttons load here so the new word is visible while valid is high
          state_d = DONE;
          load    = 1'b1;
        end else begin
          state_d = LOW;
          idx_d   = idx_q + 1'b1;
        end
      end else cnt_d = cnt_q + 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
      pend_q  <= pend_d;
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_lane
    jp_port_lane #(.N_BITS(N_BITS), .IW(IW)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .sample_i (sample),
      .load_i   (load),
      .idx_i    (idx_q),
      .data_i   (bus.jp_data[p]),
      .btn_o    (btn[p])
    );
  end

  // Pin levels decode straight from state so reset forces them asynchronously
  assign bus.jp_latch = (state_q == LATCH);
  assign bus.jp_clk   = (state_q != LOW);
  assign bus.valid    = (state_q == DONE);
  assign bus.busy     = (state_q != IDLE);
  assign bus.buttons  = btn;
endmodule

// File: tb/tb_jp_multi_reader.sv
// Bench for jp_multi_reader: 4021 pad model, latch-time scoreboard, vector table.
module tb_jp_multi_reader;
  localparam int NP = 2, NB = 8, CD = 2, LC = 4, PC = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jp_multi_reader_if #(.N_PORTS(NP), .N_BITS(NB)) bus();

  jp_multi_reader #(.N_PORTS(NP), .N_BITS(NB), .CLK_DIV(CD),
                    .LATCH_CYCLES(LC), .POLL_CYCLES(PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Pad model: serial levels, bit i is the i-th bit shifted out (active-low)
  logic [NP-1:0][NB-1:0] pad, sr;
  logic jclk_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '1;
      jclk_q <= 1'b1;
    end else begin
      jclk_q <= bus.jp_clk;
      if (bus.jp_latch) sr <= pad;
      else if (bus.jp_clk && !jclk_q)
        for (int p = 0; p < NP; p++) sr[p] <= {1'b1, sr[p][NB-1:1]};
    end
  end
  always_comb begin
    bus.jp_data = '1;
    for (int p = 0; p < NP; p++) bus.jp_data[p] = sr[p][0];
  end

  // Scoreboard: expected word pushed when pads are latched, popped on valid
  logic [NP*NB-1:0] exp_q[$];
  logic [NP-1:0][NB-1:0] m_prev, m_held, sb_raw;
  logic lat_q;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_prev = '0;
      m_held = '0;
      lat_q  = 1'b0;
    end else begin
      if (bus.jp_latch && !lat_q) begin
        sb_raw = ~pad;
`ifdef JP_DEBOUNCE_EN
        for (int p = 0; p < NP; p++) if (sb_raw[p] == m_prev[p]) m_held[p] = sb_raw[p];
        m_prev = sb_raw;
`else
        m_held = sb_raw;
`endif
        exp_q.push_back(m_held);
      end
      lat_q = bus.jp_latch;
      if (bus.valid) begin
        if (exp_q.size() == 0) check("sb_unexpected_valid", 32'd1, 32'd0);
        else check("sb_buttons", 32'(bus.buttons), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_poll();
    @(negedge clk) bus.poll_req = 1'b1;
    @(negedge clk) bus.poll_req = 1'b0;
  endtask

  task automatic wait_valid(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (bus.valid) ok = 1'b1;
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [NB-1:0] p0, p1, e0, e1;
  } vec_t;
  vec_t tv[5];

  initial begin
    bit ok;
    int lat_n, low_n, falls, badclk, vc, nv, t1, t2;
    bit prevclk, sawv;
    logic [NB-1:0] dfr[3], dex[3];

    tv[0] = '{8'b0111_1110, 8'hFF, 8'h81, 8'h00};
    tv[1] = '{8'h00, 8'hAA, 8'hFF, 8'h55};
    tv[2] = '{8'hFE, 8'h7F, 8'h01, 8'h80};
    tv[3] = '{8'h5A, 8'hC3, 8'hA5, 8'h3C};
    tv[4] = '{8'hFF, 8'h00, 8'h00, 8'hFF};

    bus.poll_req = 1'b0;
    pad = '1;

    tick(3);
    check("rst_latch",   32'(bus.jp_latch), 32'd0);
    check("rst_jpclk",   32'(bus.jp_clk),   32'd1);
    check("rst_buttons", 32'(bus.buttons),  32'd0);
    check("rst_valid",   32'(bus.valid),    32'd0);
    check("rst_busy",    32'(bus.busy),     32'd0);
    rst_n = 1'b1;
    tick(2);

    // Frame timing from LATCH entry (c=0) to the valid cycle
    pad[0] = tv[0].p0;
    pad[1] = tv[0].p1;
    pulse_poll();
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (bus.jp_latch) ok = 1'b1; else @(negedge clk);
    end
    check("latch_seen", 32'(ok), 32'd1);
    lat_n = 0; low_n = 0; falls = 0; badclk = 0; vc = -1; prevclk = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.jp_latch) lat_n++;
      if (bus.jp_latch && !bus.jp_clk) badclk++;
      if (!bus.jp_clk) low_n++;
      if (!bus.jp_clk && prevclk) falls++;
      prevclk = bus.jp_clk;
      if (bus.valid) begin
        vc = c;
        break;
      end
    end
    check("latch_cycles", 32'(lat_n), 32'd4);
    check("clk_high_in_latch", 32'(badclk), 32'd0);
    check("jpclk_low_cycles", 32'(low_n), 32'd16);
    check("jpclk_pulses", 32'(falls), 32'd8);
    check("valid_offset", 32'(vc), 32'd36);
    @(negedge clk);
    check("busy_after_done", 32'(bus.busy), 32'd0);
    check("valid_one_cycle", 32'(bus.valid), 32'd0);

    // Vector table: each pattern polled twice, field checked after the second frame
    for (int v = 0; v < 5; v++) begin
      pad[0] = tv[v].p0;
      pad[1] = tv[v].p1;
      for (int k = 0; k < 2; k++) begin
        pulse_poll();
        wait_valid(60, ok);
      end
      check($sformatf("tbl%0d_p0", v), 32'(bus.buttons[7:0]),  32'(tv[v].e0));
      check($sformatf("tbl%0d_p1", v), 32'(bus.buttons[15:8]), 32'(tv[v].e1));
    end
    tick(3);
    check("buttons_hold", 32'(bus.buttons), {16'h0, tv[4].e1, tv[4].e0});

    // Two requests during a frame merge into one extra frame
    do_reset();
    pad[0] = tv[3].p0;
    pad[1] = tv[3].p1;
    pulse_poll();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!bus.jp_clk) ok = 1'b1;
    end
    check("merge_in_low", 32'(ok), 32'd1);
    tick(3);
    pulse_poll();
    tick(4);
    pulse_poll();
    nv = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
    check("merge_frames", 32'(nv), 32'd2);
    check("merge_idle", 32'(bus.busy), 32'd0);

    // Reset asserted during the 5th LOW phase
    do_reset();
    pulse_poll();
    falls = 0; prevclk = 1'b1;
    for (int i = 0; i < 60 && falls < 5; i++) begin
      @(negedge clk);
      if (!bus.jp_clk && prevclk) falls++;
      prevclk = bus.jp_clk;
    end
    check("midrst_reached_low5", 32'(falls), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_jpclk",   32'(bus.jp_clk),   32'd1);
    check("midrst_latch",   32'(bus.jp_latch), 32'd0);
    check("midrst_busy",    32'(bus.busy),     32'd0);
    check("midrst_valid",   32'(bus.valid),    32'd0);
    check("midrst_buttons", 32'(bus.buttons),  32'd0);
    sawv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.valid) sawv = 1'b1;
    end
    rst_n = 1'b1;
    check("midrst_no_valid", 32'(sawv), 32'd0);
    pad[0] = tv[2].p0;
    pad[1] = tv[2].p1;
    for (int k = 0; k < 2; k++) begin
      pulse_poll();
      wait_valid(60, ok);
    end
    check("postrst_p0", 32'(bus.buttons[7:0]),  32'(tv[2].e0));
    check("postrst_p1", 32'(bus.buttons[15:8]), 32'(tv[2].e1));

    // Automatic polling with no requests
    do_reset();
    wait_valid(1100, ok);
    t1 = cyc;
    wait_valid(1100, ok);
    t2 = cyc;
    check("auto_period", 32'(t2 - t1), 32'd1000);

`ifdef JP_DEBOUNCE_EN
    do_reset();
    pad = '1;
    dfr[0] = 8'h01; dfr[1] = 8'h03; dfr[2] = 8'h03;
    dex[0] = 8'h00; dex[1] = 8'h00; dex[2] = 8'h03;
    for (int f = 0; f < 3; f++) begin
      pad[0] = ~dfr[f];
      pulse_poll();
      wait_valid(60, ok);
      check($sformatf("deb_valid%0d", f), 32'(ok), 32'd1);
      check($sformatf("deb_frame%0d", f), 32'(bus.buttons[7:0]), 32'(dex[f]));
    end
`else
    dfr[0] = '0; dex[0] = '0;
`endif

    tick(5);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
